// File: rtl/mcp3008_spi_responder.sv
// MCP3008-compatible SPI Mode-0 slave: decodes start/SGL/D2..D0, snapshots the
// selected channel (or clamped difference) and shifts it out on MISO.
module mcp3008_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_TAIL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [79:0] ch_data,
    input  logic        SCK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        miso_oe,
    output logic        conv_valid,
    output logic [2:0]  conv_channel,
    output logic        conv_diff,
    output logic [9:0]  conv_result,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE, WAIT_START, CMD, SAMPLE, DATA, TAIL, ZEROS
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr;
    logic sck_d;
    logic sck_s, cs_s, mosi_s, sck_rise, sck_fall;

    logic [3:0] cnt, cnt_nxt;
    logic [2:0] cmd_sr, cmd_nxt;
    logic       miso_nxt, oe_nxt, valid_nxt, diff_nxt;
    logic [2:0] chan_nxt;
    logic [9:0] res_nxt;

    logic [9:0] ch [8];
    logic [3:0] cmd_full;
    logic [9:0] in_p, in_n, calc;

    assign sck_s     = sck_sr[SYNC_STAGES-1];
    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_d;
    assign sck_fall  = ~sck_s & sck_d;
    assign state_dbg = state;

    // Command as it stands at the D0 rise: {SGL, D2, D1, D0}.
    always_comb begin
        for (int i = 0; i < 8; i++) ch[i] = ch_data[10*i +: 10];
        cmd_full = {cmd_sr, mosi_s};
        in_p     = ch[cmd_full[2:0]];
        in_n     = ch[cmd_full[2:0] ^ 3'd1];
        if (cmd_full[3])      calc = in_p;
        else if (in_p > in_n) calc = in_p - in_n;
        else                  calc = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sr  <= '0;
            cs_sr   <= '1;
            mosi_sr <= '0;
            sck_d   <= 1'b0;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], SCK};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], CS};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
            sck_d   <= sck_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            cmd_sr       <= '0;
            MISO         <= 1'b0;
            miso_oe      <= 1'b0;
            conv_valid   <= 1'b0;
            conv_channel <= '0;
            conv_diff    <= 1'b0;
            conv_result  <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            cmd_sr       <= cmd_nxt;
            MISO         <= miso_nxt;
            miso_oe      <= oe_nxt;
            conv_valid   <= valid_nxt;
            conv_channel <= chan_nxt;
            conv_diff    <= diff_nxt;
            conv_result  <= res_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cmd_nxt   = cmd_sr;
        miso_nxt  = MISO;
        oe_nxt    = miso_oe;
        valid_nxt = 1'b0;
        chan_nxt  = conv_channel;
        diff_nxt  = conv_diff;
        res_nxt   = conv_result;
        // CS high wins over any SCK edge seen in the same cycle.
        if (cs_s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            miso_nxt  = 1'b0;
            oe_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: state_nxt = WAIT_START;
                WAIT_START: begin
                    if (sck_rise && mosi_s) begin
                        state_nxt = CMD;
                        cnt_nxt   = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_nxt = {cmd_sr[1:0], mosi_s};
                        cnt_nxt = cnt + 4'd1;
                        if (cnt == 4'd3) begin
                            chan_nxt  = cmd_full[2:0];
                            diff_nxt  = ~cmd_full[3];
                            res_nxt   = calc;
                            valid_nxt = 1'b1;
                            state_nxt = SAMPLE;
                            cnt_nxt   = '0;
                        end
                    end
                end
                // cnt marks that the sampling-period rise has been seen, so the
                // fall right after D0 does not emit the null bit early.
                SAMPLE: begin
                    if (sck_rise) begin
                        cnt_nxt = 4'd1;
                    end else if (sck_fall && cnt == 4'd1) begin
                        miso_nxt  = 1'b0;
                        oe_nxt    = 1'b1;
                        state_nxt = DATA;
                        cnt_nxt   = 4'd9;
                    end
                end
                DATA: begin
                    if (sck_fall) begin
                        miso_nxt = conv_result[cnt];
                        if (cnt == 4'd0) begin
                            state_nxt = LSB_TAIL ? TAIL : ZEROS;
                            cnt_nxt   = 4'd1;
                        end else begin
                            cnt_nxt = cnt - 4'd1;
                        end
                    end
                end
                TAIL: begin
                    if (sck_fall) begin
                        miso_nxt = conv_result[cnt];
                        cnt_nxt  = cnt + 4'd1;
                        if (cnt == 4'd9) state_nxt = ZEROS;
                    end
                end
                ZEROS: begin
                    if (sck_fall) miso_nxt = 1'b0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
